program_memory_arbiter: RTL

- Shares the single combinational read port of the program memory ROM between two requesters.
- F is the processor's instruction fetch; D is a secondary reader, e.g. a debug monitor or a constant-table load from the text segment.
- The block translates MIPS byte addresses in the text segment into ROM byte offsets and registers the ROM output into one-cycle read responses.
- F has fixed priority, and a starvation counter guarantees D forward progress.

---
 rtl/program_memory_arbiter_if.sv | 34 +++
 rtl/program_memory_arbiter.sv | 80 ++++++++
 2 files changed

// File: rtl/program_memory_arbiter_if.sv
// rtl/program_memory_arbiter_if.sv - request/response and ROM port bundle for program_memory_arbiter
interface program_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  f_req;
    logic [DATA_WIDTH-1:0] f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [DATA_WIDTH-1:0] f_rdata;
    logic                  f_err;

    logic                  d_req;
    logic [DATA_WIDTH-1:0] d_addr;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_err;

    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_instr;

    // Requesters and the ROM model sit on the master side.
    modport master (
        output f_req, f_addr, d_req, d_addr, mem_instr,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  d_gnt, d_rvalid, d_rdata, d_err, mem_addr
    );

    modport slave (
        input  f_req, f_addr, d_req, d_addr, mem_instr,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output d_gnt, d_rvalid, d_rdata, d_err, mem_addr
    );
endinterface

// File: rtl/program_memory_arbiter.sv
// rtl/program_memory_arbiter.sv - two-port arbiter for the program ROM read port with starvation guard
module program_memory_arbiter #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
    parameter int                    STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    program_memory_arbiter_if.slave   bus
);
    localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(MEMORY_DEPTH * 4);
    localparam logic [3:0]            LIMIT     = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt;
    logic                  force_d;
    logic                  d_win;
    logic                  f_win;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] off;
    logic                  err;

    logic                  f_rvalid_q;
    logic                  f_err_q;
    logic [DATA_WIDTH-1:0] f_rdata_q;
    logic                  d_rvalid_q;
    logic                  d_err_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;

    // Raw grant decisions feed the flops; only the visible outputs are gated by reset.
    always_comb begin
        force_d  = (starve_cnt == LIMIT);
        d_win    = bus.d_req && (force_d || !bus.f_req);
        f_win    = bus.f_req && !d_win;
        sel_addr = d_win ? bus.d_addr : bus.f_addr;
        off      = sel_addr - TEXT_BASE;
        err      = (sel_addr[1:0] != 2'b00) || (sel_addr < TEXT_BASE) || (off >= MEM_BYTES);
    end

    assign bus.f_gnt    = reset && f_win;
    assign bus.d_gnt    = reset && d_win;
    assign bus.mem_addr = (reset && (f_win || d_win) && !err) ? off : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
            f_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            f_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            if (d_win) begin
                starve_cnt <= 4'd0;
            end else if (bus.d_req && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            f_rvalid_q <= f_win;
            f_err_q    <= f_win && err;
            if (f_win) begin
                f_rdata_q <= err ? '0 : bus.mem_instr;
            end

            d_rvalid_q <= d_win;
            d_err_q    <= d_win && err;
            if (d_win) begin
                d_rdata_q <= err ? '0 : bus.mem_instr;
            end
        end
    end

    assign bus.f_rvalid = f_rvalid_q;
    assign bus.f_err    = f_err_q;
    assign bus.f_rdata  = f_rdata_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_err    = d_err_q;
    assign bus.d_rdata  = d_rdata_q;
endmodule
